// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: examines operands CHUNK bits per cycle, MSB-first,
// and stops at the first differing slice. Supports unsigned and two's-complement modes.
module seq_comparator #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             greater,
   output logic             less,
   output logic             equal
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sm_q, sm_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
   logic [CHUNK-1:0] a_top, b_top;

   // Operands shift left after each equal slice, so the slice under test is always the top one.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      idx_d   = idx_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      a_top   = a_q[WIDTH-1 -: CHUNK];
      b_top   = b_q[WIDTH-1 -: CHUNK];

      // Flipping the sign bits maps two's-complement order onto unsigned order.
      if (sm_q && (idx_q == LAST)) begin
         a_top[CHUNK-1] = ~a_top[CHUNK-1];
         b_top[CHUNK-1] = ~b_top[CHUNK-1];
      end

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = COMPARE;
               a_d     = ain;
               b_d     = bin;
               sm_d    = signed_mode;
               idx_d   = LAST;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
            end
         end
         COMPARE: begin
            if (a_top > b_top) begin
               gt_d    = 1'b1;
               state_d = DONE;
            end else if (a_top < b_top) begin
               lt_d    = 1'b1;
               state_d = DONE;
            end else if (idx_q == '0) begin
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
               a_d   = a_q << CHUNK;
               b_d   = b_q << CHUNK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand registers are plain flops, not memory, so clearing them on reset is cheap and keeps the state deterministic.
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         idx_q   <= LAST;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         idx_q   <= idx_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   assign busy    = (state_q == COMPARE);
   assign done    = (state_q == DONE);
   assign greater = gt_q;
   assign less    = lt_q;
   assign equal   = eq_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: a 32/8 instance and a 16/16 instance on one clock.
// Stimulus pushes expected flags and done cycle; per-instance monitors pop on done.
module tb_seq_comparator;

   typedef struct {
      string name;
      logic  gt;
      logic  lt;
      logic  eq;
      int    done_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   logic        start_a = 1'b0, sm_a = 1'b0;
   logic [31:0] ain_a = '0, bin_a = '0;
   logic        busy_a, done_a, gt_a, lt_a, eq_a;

   logic        start_b = 1'b0, sm_b = 1'b0;
   logic [15:0] ain_b = '0, bin_b = '0;
   logic        busy_b, done_b, gt_b, lt_b, eq_b;

   seq_comparator #(.WIDTH(32), .CHUNK(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .signed_mode(sm_a),
      .ain(ain_a), .bin(bin_a), .busy(busy_a), .done(done_a),
      .greater(gt_a), .less(lt_a), .equal(eq_a)
   );

   seq_comparator #(.WIDTH(16), .CHUNK(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .signed_mode(sm_b),
      .ain(ain_b), .bin(bin_b), .busy(busy_b), .done(done_b),
      .greater(gt_b), .less(lt_b), .equal(eq_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: compare flags and latency whenever done is seen.
   always @(negedge clk) begin
      exp_t e;
      check("excl_a", 64'(int'(gt_a) + int'(lt_a) + int'(eq_a) <= 1), 64'd1);
      if (done_a) begin
         check("pending_a", 64'(qa.size() > 0), 64'd1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.done_cyc));
            check({e.name, "_flags"}, {61'd0, gt_a, lt_a, eq_a}, {61'd0, e.gt, e.lt, e.eq});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      check("excl_b", 64'(int'(gt_b) + int'(lt_b) + int'(eq_b) <= 1), 64'd1);
      if (done_b) begin
         check("pending_b", 64'(qb.size() > 0), 64'd1);
         if (qb.size() > 0) begin
            e = qb.pop_front();
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.done_cyc));
            check({e.name, "_flags"}, {61'd0, gt_b, lt_b, eq_b}, {61'd0, e.gt, e.lt, e.eq});
         end
      end
   end

   // Called at a negedge; the next posedge accepts, so done is expected k edges after it.
   task automatic issue_a(input logic [31:0] a, input logic [31:0] b, input logic sm, input int k,
                          input logic gt, input logic lt, input logic eq, input string name);
      ain_a = a; bin_a = b; sm_a = sm; start_a = 1'b1;
      qa.push_back('{name, gt, lt, eq, cyc + 1 + k});
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic issue_b(input logic [15:0] a, input logic [15:0] b, input logic sm, input int k,
                          input logic gt, input logic lt, input logic eq, input string name);
      ain_b = a; bin_b = b; sm_b = sm; start_b = 1'b1;
      qb.push_back('{name, gt, lt, eq, cyc + 1 + k});
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (qa.size() == 0 && qb.size() == 0) break;
         @(negedge clk);
      end
      check({name, "_timeout"}, 64'(qa.size() + qb.size()), 64'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check("reset_a", {59'd0, busy_a, done_a, gt_a, lt_a, eq_a}, 64'd0);
      check("reset_b", {59'd0, busy_b, done_b, gt_b, lt_b, eq_b}, 64'd0);
      repeat (2) @(negedge clk);

      // Release reset and start on the same negedge: the first edge must accept.
      rst_n = 1'b1;
      issue_a(32'h12345678, 32'h12345679, 1'b0, 4, 1'b0, 1'b1, 1'b0, "lsb_less");
      drain("lsb_less");

      issue_a(32'h80000000, 32'h7FFFFFFF, 1'b0, 1, 1'b1, 1'b0, 1'b0, "msb_unsigned");
      drain("msb_unsigned");
      issue_a(32'h80000000, 32'h7FFFFFFF, 1'b1, 1, 1'b0, 1'b1, 1'b0, "msb_signed");
      drain("msb_signed");

      issue_a(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4, 1'b0, 1'b0, 1'b1, "equal");
      drain("equal");
      repeat (2) @(negedge clk);
      check("hold_flags", {60'd0, done_a, gt_a, lt_a, eq_a}, 64'b0001);

      // Start while busy must be ignored, including its new operands.
      issue_a(32'h00000001, 32'h00000002, 1'b0, 4, 1'b0, 1'b1, 1'b0, "busy_ignore");
      check("busy_set", 64'(busy_a), 64'd1);
      ain_a = 32'hFF000000; bin_a = 32'h0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("busy_still", 64'(busy_a), 64'd1);
      for (int i = 0; i < 10; i++) begin
         if (done_a) break;
         @(negedge clk);
      end
      check("done_seen", 64'(done_a), 64'd1);
      // Back-to-back: start during the done cycle.
      issue_a(32'h0000AB00, 32'h0000AA00, 1'b0, 3, 1'b1, 1'b0, 1'b0, "back2back");
      check("b2b_busy", {62'd0, busy_a, done_a}, 64'b10);
      drain("back2back");

      // Reset in the 2nd COMPARE cycle aborts with no done pulse.
      issue_a(32'h11223344, 32'h11223355, 1'b0, 4, 1'b0, 1'b1, 1'b0, "aborted");
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("rst_async", {59'd0, busy_a, done_a, gt_a, lt_a, eq_a}, 64'd0);
      qa.delete();
      repeat (4) @(negedge clk);
      check("rst_no_done", {62'd0, busy_a, done_a}, 64'd0);
      rst_n = 1'b1;
      issue_a(32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 1'b0, 1'b1, 1'b0, "post_reset");
      drain("post_reset");

      // Single-chunk instance: always one cycle.
      issue_b(16'h0001, 16'hFFFF, 1'b1, 1, 1'b1, 1'b0, 1'b0, "w16_signed");
      drain("w16_signed");
      issue_b(16'h0001, 16'hFFFF, 1'b0, 1, 1'b0, 1'b1, 1'b0, "w16_unsigned");
      drain("w16_unsigned");

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
